gray_counter_ctrl: RTL and testbench
====================================

Name: gray_counter_ctrl

Overview:
Sequencing controller for the N-bit Gray counter datapath. It takes debounced, single-cycle button pulses (run/pause, single-step, clear) and produces the counter's clock-enable and synchronous-clear strobes. It contains the 1 Hz-style tick prescaler and an optional one-shot mode that stops after one full Gray cycle. It sits between the debounce/pulse stage and the gray counter, replacing the free-running pulse path.

Parameters:
N, 4, counter width of the controlled Gray counter; the shadow position counter is N bits.
DISTANCE, 100000000, clk cycles per run-mode tick (10 ns clk -> 1 Hz); legal range >= 1.
PW, 27, prescaler width; must satisfy 2^PW >= DISTANCE.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release synchronous to clk upstream)
btn_run  in  1  one-cycle pulse: toggle run/pause
btn_step  in  1  one-cycle pulse: advance counter by one when idle
btn_clr  in  1  one-cycle pulse: clear counter
oneshot  in  1  level: 1 = stop automatically after one full Gray cycle (2^N enables)
cnt_en  out  1  clock-enable to the Gray counter, one cycle per advance
cnt_clr  out  1  synchronous clear to the Gray counter, one cycle
running  out  1  high while in RUN
wrap  out  1  one-cycle pulse coincident with the cnt_en that returns the position to 0
state  out  2  current FSM state (debug/LED)

Behaviour:
- Registers: state (2b), presc (PW b), pos (N b). On rst=0: state=IDLE, presc=0, pos=0. All outputs 0 during reset.
- States/encoding: IDLE=00, RUN=01, STEP=10, CLEAR=11.
- Outputs are Moore decodes of registers only; buttons never reach outputs combinationally.
  - cnt_en = (state==STEP) | (state==RUN & presc==DISTANCE-1)
  - cnt_clr = (state==CLEAR)
  - running = (state==RUN)
  - wrap = cnt_en & (pos==2^N-1)
- Button priority when several pulse in the same cycle: clr > run > step.
- IDLE:
  - btn_clr -> CLEAR
  - else btn_run -> RUN, presc=0
  - else btn_step -> STEP
  - else stay
- RUN:
  - presc increments each cycle; at DISTANCE-1 it wraps to 0 (cnt_en high that cycle).
  - btn_clr -> CLEAR
  - else btn_run -> IDLE (pause; presc forced to 0, partial tick discarded)
  - else oneshot & wrap -> IDLE
  - else stay
  - btn_step is ignored.
- STEP: lasts exactly one cycle (cnt_en=1), then IDLE. btn_clr in that cycle -> CLEAR instead. btn_run and btn_step are ignored.
- CLEAR: lasts exactly one cycle (cnt_clr=1). pos<=0, presc<=0, next state IDLE. All buttons are ignored in this cycle.
- pos increments mod 2^N on every cycle with cnt_en=1. pos is not changed by pause.
- Latency:
  - btn_step at cycle t -> cnt_en at t+1.
  - btn_clr at t -> cnt_clr at t+1.
  - btn_run at t -> RUN from t+1; first cnt_en at t+DISTANCE, then every DISTANCE cycles.
- Simultaneous tick and button: a tick (presc==DISTANCE-1 in RUN) still issues cnt_en in that cycle even if btn_clr or btn_run is present. The button then takes effect at the next edge.
- DISTANCE=1: cnt_en is high every RUN cycle.
- oneshot sampled each cycle: deasserting mid-run disables the auto-stop; asserting it mid-run stops at the next wrap.
- Reset mid-RUN: counting stops immediately and all outputs go to 0 asynchronously.

Test Plan:
(Sim parameters: N=2, DISTANCE=4.)
1. Reset, then btn_step pulse at cycle 10 -> cnt_en=1 only at cycle 11, state 10 at cycle 11, back to 00 at cycle 12. pos=1.
2. btn_run at cycle 0 (oneshot=0) -> cnt_en at cycles 4,8,12,16. wrap=1 only at cycle 16. running=1 throughout; pos after cycle 16 = 0.
3. oneshot=1, btn_run at cycle 0 -> four cnt_en pulses (4,8,12,16), wrap at 16, state=IDLE at cycle 17, no cnt_en afterward.
4. Running with presc==3 when btn_clr arrives -> cnt_en=1 that cycle, cnt_clr=1 next cycle, then IDLE with pos=0 and presc=0.
5. btn_clr, btn_run and btn_step pulsed together in IDLE -> CLEAR only (cnt_clr one cycle), then IDLE. Pause via btn_run at presc=2, resume -> next cnt_en exactly 4 cycles after resume.
6. Assert rst=0 asynchronously mid-RUN between clock edges -> cnt_en, running and state drop to 0 before the next edge. After release, no activity occurs without a button.

Source files
------------

// File: rtl/gray_counter_ctrl.sv
`default_nettype none
// gray_counter_ctrl: run/pause/step/clear sequencer with tick prescaler and one-shot
// auto-stop, driving the Gray counter's clock-enable and synchronous clear.
module gray_counter_ctrl #(
  parameter int N        = 4,
  parameter int DISTANCE = 100000000,
  parameter int PW       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_clr,
  input  logic       oneshot,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic       wrap,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DISTANCE - 1);
  localparam logic [N-1:0]  POS_LAST   = '1;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [N-1:0]  pos_q,   pos_d;
  logic          tick_w;
  logic          en_w;
  logic          wrap_w;

  // Outputs decode registered state only, so button pulses never reach them combinationally.
  assign tick_w  = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign en_w    = (state_q == STEP) || tick_w;
  assign wrap_w  = en_w && (pos_q == POS_LAST);

  assign cnt_en  = en_w;
  assign cnt_clr = (state_q == CLEAR);
  assign running = (state_q == RUN);
  assign wrap    = wrap_w;
  assign state   = state_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pos_d   = pos_q;
    if (en_w) begin
      pos_d = pos_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (btn_clr) begin
          state_d = CLEAR;
        end else if (btn_run) begin
          state_d = RUN;
          presc_d = '0;
        end else if (btn_step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        presc_d = tick_w ? '0 : presc_q + 1'b1;
        // A tick in this cycle has already issued its enable; a button acts from the next edge.
        if (btn_clr) begin
          state_d = CLEAR;
        end else if (btn_run) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (oneshot && wrap_w) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        state_d = btn_clr ? CLEAR : IDLE;
      end
      CLEAR: begin
        state_d = IDLE;
        presc_d = '0;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_ctrl.sv
`default_nettype none
// tb_gray_counter_ctrl: directed scenario tasks for gray_counter_ctrl with N=2, DISTANCE=4,
// plus a DISTANCE=1 instance sharing the same stimulus.
module tb_gray_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_run;
  logic       btn_step;
  logic       btn_clr;
  logic       oneshot;
  logic       cnt_en;
  logic       cnt_clr;
  logic       running;
  logic       wrap;
  logic [1:0] state;
  logic       cnt_en1;
  logic       cnt_clr1;
  logic       running1;
  logic       wrap1;
  logic [1:0] state1;

  int vectors;
  int miscompares;

  gray_counter_ctrl #(.N(2), .DISTANCE(4), .PW(3)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_clr(btn_clr),
    .oneshot(oneshot), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .running(running),
    .wrap(wrap), .state(state)
  );

  gray_counter_ctrl #(.N(2), .DISTANCE(1), .PW(1)) dut1 (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_clr(btn_clr),
    .oneshot(oneshot), .cnt_en(cnt_en1), .cnt_clr(cnt_clr1), .running(running1),
    .wrap(wrap1), .state(state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if ({cnt_en, cnt_clr, running, wrap, state} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=000000", {cnt_en, cnt_clr, running, wrap, state});
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (state !== 2'b00 || cnt_en !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle i=%0d state=%b cnt_en=%b want 00/0", i, state, cnt_en);
      end
    end
  endtask

  task automatic test_step();
    btn_step = 1'b1;
    step();
    btn_step = 1'b0;
    vectors++;
    if (cnt_en !== 1'b1 || state !== 2'b10 || wrap !== 1'b0 || cnt_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL step_pulse en=%b state=%b wrap=%b clr=%b want 1/10/0/0", cnt_en, state, wrap, cnt_clr);
    end
    step();
    vectors++;
    if (cnt_en !== 1'b0 || state !== 2'b00 || dut.pos_q !== 2'd1) begin
      miscompares++;
      $display("FAIL step_after en=%b state=%b pos=%0d want 0/00/1", cnt_en, state, dut.pos_q);
    end
  endtask

  task automatic test_clear();
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
    vectors++;
    if (cnt_clr !== 1'b1 || state !== 2'b11 || cnt_en !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_pulse clr=%b state=%b en=%b want 1/11/0", cnt_clr, state, cnt_en);
    end
    step();
    vectors++;
    if (cnt_clr !== 1'b0 || state !== 2'b00 || dut.pos_q !== 2'd0) begin
      miscompares++;
      $display("FAIL clear_after clr=%b state=%b pos=%0d want 0/00/0", cnt_clr, state, dut.pos_q);
    end
  endtask

  task automatic test_run_free();
    oneshot = 1'b0;
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      vectors++;
      if (cnt_en !== (c % 4 == 0) || wrap !== (c == 16) || running !== 1'b1) begin
        miscompares++;
        $display("FAIL run_free c=%0d en=%b wrap=%b run=%b want %b/%b/1",
                 c, cnt_en, wrap, running, (c % 4 == 0), (c == 16));
      end
      step();
    end
    vectors++;
    if (dut.pos_q !== 2'd0 || running !== 1'b1 || state !== 2'b01) begin
      miscompares++;
      $display("FAIL run_free_c17 pos=%0d run=%b state=%b want 0/1/01", dut.pos_q, running, state);
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    vectors++;
    if (state !== 2'b00 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL run_pause state=%b run=%b want 00/0", state, running);
    end
  endtask

  task automatic test_oneshot();
    oneshot = 1'b1;
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      vectors++;
      if (cnt_en !== (c % 4 == 0) || wrap !== (c == 16) || state !== 2'b01) begin
        miscompares++;
        $display("FAIL oneshot c=%0d en=%b wrap=%b state=%b want %b/%b/01",
                 c, cnt_en, wrap, state, (c % 4 == 0), (c == 16));
      end
      step();
    end
    for (int c = 17; c <= 22; c++) begin
      vectors++;
      if (state !== 2'b00 || cnt_en !== 1'b0 || running !== 1'b0) begin
        miscompares++;
        $display("FAIL oneshot_stop c=%0d state=%b en=%b run=%b want 00/0/0", c, state, cnt_en, running);
      end
      step();
    end
    oneshot = 1'b0;
  endtask

  task automatic test_clr_on_tick();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    repeat (3) step();
    vectors++;
    if (cnt_en !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_tick_en en=%b want 1", cnt_en);
    end
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
    vectors++;
    if (cnt_clr !== 1'b1 || state !== 2'b11 || cnt_en !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_tick_clr clr=%b state=%b en=%b want 1/11/0", cnt_clr, state, cnt_en);
    end
    step();
    vectors++;
    if (state !== 2'b00 || dut.pos_q !== 2'd0 || dut.presc_q !== 3'd0 || cnt_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_tick_idle state=%b pos=%0d presc=%0d clr=%b want 00/0/0/0",
               state, dut.pos_q, dut.presc_q, cnt_clr);
    end
  endtask

  task automatic test_priority();
    btn_clr  = 1'b1;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    step();
    btn_clr  = 1'b0;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    vectors++;
    if (state !== 2'b11 || cnt_clr !== 1'b1 || cnt_en !== 1'b0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL priority state=%b clr=%b en=%b run=%b want 11/1/0/0", state, cnt_clr, cnt_en, running);
    end
    step();
    vectors++;
    if (state !== 2'b00 || cnt_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL priority_after state=%b clr=%b want 00/0", state, cnt_clr);
    end
  endtask

  task automatic test_pause_resume();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    repeat (2) step();
    vectors++;
    if (cnt_en !== 1'b0 || dut.presc_q !== 3'd2) begin
      miscompares++;
      $display("FAIL pause_presc en=%b presc=%0d want 0/2", cnt_en, dut.presc_q);
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (state !== 2'b00 || cnt_en !== 1'b0) begin
        miscompares++;
        $display("FAIL paused i=%0d state=%b en=%b want 00/0", i, state, cnt_en);
      end
      step();
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (cnt_en !== (k == 4) || running !== 1'b1) begin
        miscompares++;
        $display("FAIL resume k=%0d en=%b run=%b want %b/1", k, cnt_en, running, (k == 4));
      end
      if (k < 4) step();
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    vectors++;
    if (state !== 2'b00 || cnt_en !== 1'b0) begin
      miscompares++;
      $display("FAIL resume_pause state=%b en=%b want 00/0", state, cnt_en);
    end
  endtask

  task automatic test_distance1();
    btn_clr = 1'b1;
    step();
    btn_clr = 1'b0;
    step();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (cnt_en1 !== 1'b1 || running1 !== 1'b1 || wrap1 !== (c == 4)) begin
        miscompares++;
        $display("FAIL dist1 c=%0d en=%b run=%b wrap=%b want 1/1/%b", c, cnt_en1, running1, wrap1, (c == 4));
      end
      step();
    end
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    vectors++;
    if (state1 !== 2'b00 || cnt_en1 !== 1'b0 || state !== 2'b00) begin
      miscompares++;
      $display("FAIL dist1_pause state1=%b en1=%b state=%b want 00/0/00", state1, cnt_en1, state);
    end
  endtask

  task automatic test_async_reset();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    repeat (3) step();
    vectors++;
    if (cnt_en !== 1'b1 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre en=%b run=%b want 1/1", cnt_en, running);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (cnt_en !== 1'b0 || running !== 1'b0 || state !== 2'b00 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_mid en=%b run=%b state=%b wrap=%b want 0/0/00/0", cnt_en, running, state, wrap);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (cnt_en !== 1'b0 || cnt_clr !== 1'b0 || state !== 2'b00) begin
        miscompares++;
        $display("FAIL areset_quiet i=%0d en=%b clr=%b state=%b want 0/0/00", i, cnt_en, cnt_clr, state);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    btn_run     = 1'b0;
    btn_step    = 1'b0;
    btn_clr     = 1'b0;
    oneshot     = 1'b0;
    test_reset();
    test_step();
    test_clear();
    test_run_free();
    test_oneshot();
    test_clr_on_tick();
    test_priority();
    test_pause_resume();
    test_distance1();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
